// File: rtl/prbs_pkg.sv
// prbs_pkg: shared PRBS-8 tap mask, checker state encoding and next-state function.
package prbs_pkg;
  localparam logic [7:0] TAP_MASK = 8'hB8;
  typedef enum logic [1:0] {SEED, VERIFY, LOCKED} state_t;
  function automatic logic [7:0] next(input logic [7:0] s);
    return {s[6:0], ^(s & TAP_MASK)};
  endfunction
endpackage

// File: rtl/prbs_lfsr_next.sv
// prbs_lfsr_next: combinational x^8+x^6+x^5+x^4+1 next-state, shared with the generator.
module prbs_lfsr_next
  import prbs_pkg::*;
(
  input  logic [7:0] state,
  output logic [7:0] state_next
);
  assign state_next = next(state);
endmodule

// File: rtl/prbs_checker.sv
// prbs_checker: locks onto an 8-bit PRBS stream and counts errors while locked.
// Define PRBS_CHECKER_STATS_EN to enable the valid-byte counter on byte_count.
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  data_in,
  input  logic        data_valid,
  input  logic        err_clear,
  output logic        locked,
  output logic        err_pulse,
  output logic        lost_pulse,
  output logic [15:0] err_count,
  output logic [31:0] byte_count
);
  state_t state, state_d;
  logic [7:0] pred, pred_d, nxt;
  logic [3:0] match_cnt, match_d, miss_cnt, miss_d;
  logic err_d, lost_d, hit;
  assign hit = data_in == pred;
  // On a match data_in equals pred, so one generator serves both reseed and advance.
  prbs_lfsr_next u_next (
    .state      (state == LOCKED ? pred : data_in),
    .state_next (nxt)
  );
  always_comb begin
    state_d = state;
    pred_d = pred;
    match_d = match_cnt;
    miss_d = miss_cnt;
    err_d = 1'b0;
    lost_d = 1'b0;
    if (data_valid) begin
      case (state)
        SEED: if (data_in != 8'h00) begin
          pred_d = nxt;
          match_d = '0;
          state_d = VERIFY;
        end
        VERIFY: if (hit) begin
          pred_d = nxt;
          match_d = match_cnt + 4'd1;
          if (match_d == 4'(LOCK_COUNT)) begin
            state_d = LOCKED;
            miss_d = '0;
          end
        end else if (data_in != 8'h00) begin
          pred_d = nxt;
          match_d = '0;
        end else state_d = SEED;
        LOCKED: begin
          pred_d = nxt;
          miss_d = hit ? 4'd0 : miss_cnt + 4'd1;
          err_d = !hit;
          if (!hit && miss_d == 4'(LOSS_COUNT)) begin
            state_d = SEED;
            lost_d = 1'b1;
            miss_d = '0;
          end
        end
        default: state_d = SEED;
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SEED;
      pred <= '0;
      match_cnt <= '0;
      miss_cnt <= '0;
      err_pulse <= 1'b0;
      lost_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      state <= state_d;
      pred <= pred_d;
      match_cnt <= match_d;
      miss_cnt <= miss_d;
      err_pulse <= err_d;
      lost_pulse <= lost_d;
      err_count <= err_clear ? 16'd0 : (err_d && err_count != 16'hFFFF) ? err_count + 16'd1 : err_count;
    end
  end
  assign locked = state == LOCKED;
`ifdef PRBS_CHECKER_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) byte_count <= '0;
    else if (data_valid) byte_count <= byte_count + 32'd1;
  end
`else
  assign byte_count = '0;
`endif
endmodule
